// File: rtl/bfs_pkg.sv
// Shared definitions for the frontier bitmask scanner: FSM encoding and
// the derivation of the bit-index width from the word width.
package bfs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } scan_state_t;

  function automatic int bit_width_of(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit finder; index is zero when no bit is set.
module lsb_priority_encoder
  import bfs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = bit_width_of(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic                  any
);

  always_comb begin
    idx = '0;
    any = |data;
    // Walk from the top so the lowest set bit is the last one written.
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (data[i]) idx = IDX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/frontier_bitmask_scanner.sv
// Scans a single-port frontier bitmask from word 0, emitting the vertex ID of
// every set bit over a valid/ready stream, optionally clearing words as read.
//
// state  | meaning
// IDLE   | waiting for start; vid_count holds the last scan's total
// FETCH  | read word_idx into shadow, optionally write it back as zero
// EMIT   | present lowest set bit of shadow until accepted
// FINISH | one-cycle done pulse
module frontier_bitmask_scanner
  import bfs_pkg::*;
#(
  parameter  int ADDR_WIDTH = 10,
  parameter  int DATA_WIDTH = 32,
  localparam int BIT_WIDTH  = bit_width_of(DATA_WIDTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            clear_en,
  input  logic [ADDR_WIDTH:0]             word_count,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0]           mem_dout,
  output logic                            mem_we,
  output logic [DATA_WIDTH-1:0]           mem_din,
  output logic                            vid_valid,
  input  logic                            vid_ready,
  output logic [ADDR_WIDTH+BIT_WIDTH-1:0] vid,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH+BIT_WIDTH:0]   vid_count
);

  localparam int VC_WIDTH = ADDR_WIDTH + BIT_WIDTH + 1;

  scan_state_t           state;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH:0]   wc_lat;
  logic                  clr_lat;
  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] shadow_rest;
  logic [BIT_WIDTH-1:0]  enc_idx;
  logic                  enc_any;
  logic                  last_word;

  lsb_priority_encoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (BIT_WIDTH)
  ) u_lsb (
    .data (shadow),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  // Dropping the lowest set bit: x & (x-1).
  assign shadow_rest = shadow & (shadow - DATA_WIDTH'(1));

  // Saturate at the top address so word_idx never wraps for oversize counts.
  assign last_word = (({1'b0, word_idx} + (ADDR_WIDTH+1)'(1)) >= wc_lat) || (&word_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_idx  <= '0;
      wc_lat    <= '0;
      clr_lat   <= 1'b0;
      shadow    <= '0;
      vid_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            clr_lat   <= clear_en;
            wc_lat    <= word_count;
            word_idx  <= '0;
            vid_count <= '0;
            state     <= (word_count == '0) ? FINISH : FETCH;
          end
        end
        FETCH: begin
          shadow <= mem_dout;
          if (mem_dout != '0) begin
            state <= EMIT;
          end else if (last_word) begin
            state <= FINISH;
          end else begin
            word_idx <= word_idx + ADDR_WIDTH'(1);
          end
        end
        EMIT: begin
          if (vid_ready) begin
            shadow    <= shadow_rest;
            vid_count <= vid_count + VC_WIDTH'(1);
            if (shadow_rest == '0) begin
              if (last_word) begin
                state <= FINISH;
              end else begin
                word_idx <= word_idx + ADDR_WIDTH'(1);
                state    <= FETCH;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = word_idx;
  assign mem_we    = (state == FETCH) && clr_lat;
  assign mem_din   = '0;
  assign vid_valid = (state == EMIT) && enc_any;
  assign vid       = vid_valid ? {word_idx, enc_idx} : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

endmodule

// File: tb/tb_frontier_bitmask_scanner.sv
// Directed bench for frontier_bitmask_scanner with a behavioural bitmask RAM.
module tb_frontier_bitmask_scanner;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              clear_en = 1'b0;
  logic [AW:0]       word_count = '0;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_dout;
  logic              mem_we;
  logic [DW-1:0]     mem_din;
  logic              vid_valid;
  logic              vid_ready = 1'b0;
  logic [AW+BW-1:0]  vid;
  logic              busy;
  logic              done;
  logic [AW+BW:0]    vid_count;

  logic [DW-1:0]     mem [0:(1<<AW)-1];
  logic              ld_en = 1'b0;
  logic [AW-1:0]     ld_addr = '0;
  logic [DW-1:0]     ld_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_din;
  end

  frontier_bitmask_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear_en   (clear_en),
    .word_count (word_count),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .vid_valid  (vid_valid),
    .vid_ready  (vid_ready),
    .vid        (vid),
    .busy       (busy),
    .done       (done),
    .vid_count  (vid_count)
  );

  typedef struct {
    logic [31:0] w0, w1, w2, w3;
    int          wc;
    logic        clr;
    int          n;
    int          sum;
    int          first;
    int          last;
    int          cycles;
    int          we_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [31:0] words [4];
    int cyc, n, sum, first, last, we_cnt;
    bit got;
    words[0] = v.w0; words[1] = v.w1; words[2] = v.w2; words[3] = v.w3;
    for (int i = 0; i < 4; i++) load(i, words[i]);
    @(negedge clk);
    start = 1'b1;
    word_count = (AW+1)'(v.wc);
    clear_en = v.clr;
    vid_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; n = 0; sum = 0; first = -1; last = -1; we_cnt = 0; got = 0;
    while (cyc <= 200 && !got) begin
      if (mem_we) we_cnt++;
      if (vid_valid && vid_ready) begin
        if (n == 0) first = int'(vid);
        last = int'(vid);
        sum += int'(vid);
        n++;
      end
      if (done) got = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check($sformatf("v%0d done_seen", k), got, 1);
    check($sformatf("v%0d cycles", k), cyc, v.cycles);
    check($sformatf("v%0d vid_num", k), n, v.n);
    check($sformatf("v%0d vid_sum", k), sum, v.sum);
    check($sformatf("v%0d vid_count", k), vid_count, v.n);
    check($sformatf("v%0d we_pulses", k), we_cnt, v.we_cnt);
    if (v.n > 0) begin
      check($sformatf("v%0d first_vid", k), first, v.first);
      check($sformatf("v%0d last_vid", k), last, v.last);
    end
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", k), done, 0);
    check($sformatf("v%0d busy_idle", k), busy, 0);
    @(negedge clk);
    check($sformatf("v%0d vid_count_hold", k), vid_count, v.n);
    for (int i = 0; i < v.wc && i < 4; i++)
      check($sformatf("v%0d mem%0d_after", k, i), mem[i], v.clr ? 32'h0 : words[i]);
    vid_ready = 1'b0;
    clear_en = 1'b0;
  endtask

  initial begin
    int cyc;
    vecs[0] = '{w0:32'h0000_0005, w1:32'h8000_0000, w2:0, w3:0, wc:2, clr:0,
                n:3, sum:65, first:0, last:63, cycles:6, we_cnt:0};
    vecs[1] = '{w0:0, w1:0, w2:0, w3:0, wc:4, clr:0,
                n:0, sum:0, first:0, last:0, cycles:5, we_cnt:0};
    vecs[2] = '{w0:0, w1:0, w2:0, w3:32'hFFFF_FFFF, wc:4, clr:1,
                n:32, sum:3568, first:96, last:127, cycles:37, we_cnt:4};
    vecs[3] = '{w0:32'h0000_0001, w1:0, w2:0, w3:0, wc:0, clr:0,
                n:0, sum:0, first:0, last:0, cycles:1, we_cnt:0};
    vecs[4] = '{w0:0, w1:32'h0000_0100, w2:32'h0000_0001, w3:32'h0000_1234, wc:3, clr:1,
                n:2, sum:104, first:40, last:64, cycles:6, we_cnt:3};
    vecs[5] = '{w0:32'h8000_0001, w1:32'h0000_00FF, w2:0, w3:0, wc:1, clr:0,
                n:2, sum:31, first:0, last:31, cycles:4, we_cnt:0};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst vid_valid", vid_valid, 0);
    check("rst mem_we", mem_we, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst vid", vid, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst vid_count", vid_count, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Backpressure: vid_ready 0,1,0,1 across the EMIT cycles; stray start ignored.
    load(0, 32'h0000_0003);
    @(negedge clk);
    start = 1'b1; word_count = 1; clear_en = 1'b0; vid_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("stall fetch_no_valid", vid_valid, 0);
    @(negedge clk);
    check("stall valid0", vid_valid, 1);
    check("stall vid0_a", vid, 0);
    start = 1'b1; word_count = 5;
    @(negedge clk);
    start = 1'b0;
    check("stall vid0_b", vid, 0);
    check("stall valid_b", vid_valid, 1);
    vid_ready = 1'b1;
    @(negedge clk);
    check("stall vid1_a", vid, 1);
    check("stall valid_c", vid_valid, 1);
    vid_ready = 1'b0;
    @(negedge clk);
    check("stall vid1_b", vid, 1);
    check("stall count_mid", vid_count, 1);
    vid_ready = 1'b1;
    @(negedge clk);
    check("stall done", done, 1);
    check("stall no_valid_finish", vid_valid, 0);
    check("stall vid_count", vid_count, 2);
    vid_ready = 1'b0;
    @(negedge clk);
    check("stall idle_after", busy, 0);

    // Reset while EMIT is presenting an ID.
    load(0, 32'h0000_000F);
    load(1, 32'h0000_0005);
    @(negedge clk);
    start = 1'b1; word_count = 2; clear_en = 1'b1; vid_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!vid_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("rstmid valid_reached", vid_valid, 1);
    rst_n = 1'b0;
    vid_ready = 1'b1;
    @(negedge clk);
    check("rstmid vid_valid", vid_valid, 0);
    check("rstmid vid", vid, 0);
    check("rstmid mem_we", mem_we, 0);
    check("rstmid busy", busy, 0);
    check("rstmid done", done, 0);
    check("rstmid mem_addr", mem_addr, 0);
    check("rstmid vid_count", vid_count, 0);
    rst_n = 1'b1;
    vid_ready = 1'b0;
    clear_en = 1'b0;
    @(negedge clk);
    check("rstmid mem0_cleared", mem[0], 32'h0);
    check("rstmid mem1_untouched", mem[1], 32'h0000_0005);
    start = 1'b1; word_count = 0;
    @(negedge clk);
    start = 1'b0;
    check("rstmid done_pulse", done, 1);
    check("rstmid count_zero", vid_count, 0);
    @(negedge clk);
    check("rstmid done_drop", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
